// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALUOp codes,
// datapath mux encodings and the main-control state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_e;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS CPU: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables, mux selects and ALUOp.
module multicycle_main_control
    import mips_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit HAS_MEM_WAIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               ext_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               rdy;
    logic               enc_ok;
    state_e             cur;
    state_e             nxt;

    assign rdy       = HAS_MEM_WAIT ? mem_ready : 1'b1;
    // Encodings with any bit above the enum width set are illegal and fall to default.
    assign enc_ok    = ((state_q >> 4) == '0);
    assign cur       = state_e'(state_q[3:0]);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        nxt           = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        ext_op        = ~is_zext_op(op);
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        if (enc_ok) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = rdy;
                    pc_write  = rdy;
                    nxt       = rdy ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Speculatively compute the branch target into ALUOut.
                    alu_src_b = SRCB_BRANCH;
                    case (op)
                        OP_RTYPE:                 nxt = S_R_EXEC;
                        OP_LW, OP_SW:             nxt = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:           nxt = S_BRANCH;
                        OP_J:                     nxt = S_JUMP;
                        OP_ADDI, OP_SLTI, OP_ANDI,
                        OP_ORI, OP_XORI, OP_LUI:  nxt = S_I_EXEC;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                            nxt        = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    nxt       = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    nxt      = rdy ? S_MEM_WB : S_MEM_READ;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = rdy;
                    nxt        = rdy ? S_FETCH : S_MEM_WRITE;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_RTYPE;
                    nxt       = S_R_WB;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_IMM;
                    nxt       = S_I_WB;
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    branch_ne     = (op == OP_BNE);
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                default: nxt = S_FETCH;
            endcase
        end

        // Reset forces every output low, aborting any in-flight access.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_B;
            alu_op        = ALUOP_ADD;
            pc_source     = PCSRC_ALU;
            ext_op        = 1'b0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end

        state_d = STATE_W'(nxt);
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: per-cycle expected control words and states are
// queued as each cycle is driven and compared on the following falling edge.
module tb_multicycle_main_control;
    import mips_pkg::*;

    localparam int W = 20;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_op;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ext_op, instr_done, illegal_op;
    logic [3:0] dbg_state;
    logic [W-1:0] act;

    logic [W-1:0] exp_q[$];
    logic [3:0]   st_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.STATE_W(4), .HAS_MEM_WAIT(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .ext_op(ext_op), .instr_done(instr_done),
        .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    assign act = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  ext_op, instr_done, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected control word for one cycle, straight from the per-state output table.
    function automatic logic [W-1:0] exp_ctl(input state_e st, input logic r,
                                             input logic [5:0] o, input logic mr,
                                             input logic ill);
        ctl_t c;
        c = '0;
        if (r) return '0;
        c.ext_op = !(o == 6'h0C || o == 6'h0D || o == 6'h0E);
        case (st)
            S_FETCH:     begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            S_DECODE:    begin c.alu_src_b = 2'b11; c.illegal_op = ill; c.instr_done = ill; end
            S_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEM_READ:  begin c.mem_read = 1; c.iord = 1; end
            S_MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            S_MEM_WRITE: begin c.mem_write = 1; c.iord = 1; c.instr_done = mr; end
            S_R_EXEC:    begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_R_WB:      begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
            S_I_EXEC:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            S_I_WB:      begin c.reg_write = 1; c.instr_done = 1; end
            S_BRANCH:    begin
                c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.branch_ne = (o == 6'h05); c.instr_done = 1;
            end
            S_JUMP:      begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            default:     c = '0;
        endcase
        return c;
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic mr,
                        input state_e st, input logic ill, input string tag);
        @(posedge clk);
        #1;
        rst = r; op = o; mem_ready = mr;
        exp_q.push_back(exp_ctl(st, r, o, mr, ill));
        st_q.push_back(st);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            string t;
            t = tag_q.pop_front();
            check({"ctl ", t}, 32'(act), 32'(exp_q.pop_front()));
            check({"state ", t}, 32'(dbg_state), 32'(st_q.pop_front()));
        end
    end

    task automatic fetch(input logic [5:0] o, input int waits);
        for (int i = 0; i < waits; i++) step(0, o, 0, S_FETCH, 0, "fetch_wait");
        step(0, o, 1, S_FETCH, 0, "fetch");
        step(0, o, 1, S_DECODE, 0, "decode");
    endtask

    task automatic run_r(input int fw);
        fetch(6'h00, fw);
        step(0, 6'h00, 1, S_R_EXEC, 0, "r_exec");
        step(0, 6'h00, 1, S_R_WB, 0, "r_wb");
    endtask

    task automatic run_i(input logic [5:0] o, input int fw);
        fetch(o, fw);
        step(0, o, 1, S_I_EXEC, 0, "i_exec");
        step(0, o, 1, S_I_WB, 0, "i_wb");
    endtask

    task automatic run_lw(input int fw, input int mw);
        fetch(6'h23, fw);
        step(0, 6'h23, 1, S_MEM_ADDR, 0, "lw_addr");
        for (int i = 0; i < mw; i++) step(0, 6'h23, 0, S_MEM_READ, 0, "lw_read_wait");
        step(0, 6'h23, 1, S_MEM_READ, 0, "lw_read");
        step(0, 6'h23, 1, S_MEM_WB, 0, "lw_wb");
    endtask

    task automatic run_sw(input int fw, input int mw);
        fetch(6'h2B, fw);
        step(0, 6'h2B, 1, S_MEM_ADDR, 0, "sw_addr");
        for (int i = 0; i < mw; i++) step(0, 6'h2B, 0, S_MEM_WRITE, 0, "sw_write_wait");
        step(0, 6'h2B, 1, S_MEM_WRITE, 0, "sw_write");
    endtask

    task automatic run_br(input logic [5:0] o, input int fw);
        fetch(o, fw);
        step(0, o, 1, S_BRANCH, 0, "branch");
    endtask

    task automatic run_j(input int fw);
        fetch(6'h02, fw);
        step(0, 6'h02, 1, S_JUMP, 0, "jump");
    endtask

    initial begin
        logic [5:0] i_ops [6];
        i_ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        rst = 1'b1; op = 6'h00; mem_ready = 1'b0;

        step(1, 6'h00, 0, S_FETCH, 0, "reset0");
        step(1, 6'h00, 1, S_FETCH, 0, "reset1");
        run_r(0);
        run_lw(0, 3);
        run_br(6'h05, 0);
        run_br(6'h04, 0);
        run_i(6'h0D, 0);
        run_i(6'h08, 0);
        step(0, 6'h3F, 1, S_FETCH, 0, "ill_fetch");
        step(0, 6'h3F, 1, S_DECODE, 1, "ill_decode");
        run_j(1);
        run_sw(2, 1);

        // Reset arriving while a store is still waiting on memory.
        fetch(6'h2B, 0);
        step(0, 6'h2B, 1, S_MEM_ADDR, 0, "sw_addr");
        step(0, 6'h2B, 0, S_MEM_WRITE, 0, "sw_pre_rst");
        step(1, 6'h2B, 0, S_MEM_WRITE, 0, "sw_rst");
        step(0, 6'h00, 1, S_FETCH, 0, "post_rst_fetch");
        step(0, 6'h00, 1, S_DECODE, 0, "post_rst_decode");
        step(0, 6'h00, 1, S_R_EXEC, 0, "r_exec");
        step(0, 6'h00, 1, S_R_WB, 0, "r_wb");

        for (int n = 0; n < 40; n++) begin
            int fw;
            fw = $urandom_range(0, 2);
            case ($urandom_range(0, 6))
                0: run_r(fw);
                1: run_i(i_ops[$urandom_range(0, 5)], fw);
                2: run_lw(fw, $urandom_range(0, 3));
                3: run_sw(fw, $urandom_range(0, 3));
                4: run_br($urandom_range(0, 1) ? 6'h05 : 6'h04, fw);
                5: run_j(fw);
                default: begin
                    step(0, 6'h3F, 1, S_FETCH, 0, "ill_fetch");
                    step(0, 6'h3F, 1, S_DECODE, 1, "ill_decode");
                end
            endcase
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
